// File: rtl/axis_split_pkg.sv
// Shared types for the tuser-driven AXIS splitter.
// Buffer state enum, beat layout and index-width helper.
package axis_split_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  localparam int BEAT_DATA_W = 32;
  localparam int BEAT_USER_W = 2;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic [BEAT_USER_W-1:0] user;
  } beat_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_split_tuser_skid.sv
// Generic 2-entry skid buffer: main register drives the output,
// skid register absorbs one beat so in_ready stays registered.
module axis_skid_buf
  import axis_split_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             ready_q;
  logic             accept, pop;
  logic             ld_main_in, ld_main_skid, ld_skid;

  assign accept    = in_valid & ready_q;
  assign pop       = (state_q != EMPTY) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  // Next-state and register-load selection.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid = 1'b1;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          ld_main_skid = 1'b1;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, entries and registered ready.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
      if (ld_main_in) begin
        main_q <= in_data;
      end else if (ld_main_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/axis_split_tuser.sv
// Routes a merged AXIS stream to MASTER_NUM outputs by tuser.
// Optional per-output beat counters: AXIS_SPLIT_BEAT_CNT_EN.
module axis_split_tuser
  import axis_split_pkg::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = idx_width(MASTER_NUM),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            s_tvalid_i,
  output logic                            s_tready_o,
  input  logic [DATA_WIDTH-1:0]           s_tdata_i,
  input  logic [USER_WIDTH-1:0]           s_tuser_i,
  output logic [MASTER_NUM-1:0]           m_tvalid_o,
  input  logic [MASTER_NUM-1:0]           m_tready_i,
  output logic [DATA_WIDTH-1:0]           m_tdata_o,
  output logic [USER_WIDTH-1:0]           m_tuser_o,
  output logic                            drop_err_o,
  output logic [CNT_WIDTH-1:0]            drop_cnt_o,
  output logic [MASTER_NUM*CNT_WIDTH-1:0] beat_cnt_o
);

  localparam int PW = DATA_WIDTH + USER_WIDTH;

  logic [PW-1:0]         head;
  logic                  head_valid, head_ready;
  logic [USER_WIDTH-1:0] sel;
  logic                  oor, sel_ready, drop;
  logic [CNT_WIDTH-1:0]  drop_cnt_q;
  logic                  drop_err_q;

  axis_skid_buf #(
    .WIDTH(PW)
  ) u_skid (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .in_valid (s_tvalid_i),
    .in_ready (s_tready_o),
    .in_data  ({s_tdata_i, s_tuser_i}),
    .out_valid(head_valid),
    .out_ready(head_ready),
    .out_data (head)
  );

  assign sel       = head[USER_WIDTH-1:0];
  assign m_tuser_o = sel;
  assign m_tdata_o = head[PW-1:USER_WIDTH];
  assign oor       = (32'(sel) >= 32'(MASTER_NUM));

  // Demux valid to the selected output and pick its ready.
  always_comb begin
    m_tvalid_o = '0;
    sel_ready  = 1'b0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (sel == USER_WIDTH'(i)) begin
        m_tvalid_o[i] = head_valid & ~oor;
        sel_ready     = m_tready_i[i];
      end
    end
  end

  assign head_ready = oor | sel_ready;
  assign drop       = head_valid & oor;

  // Sticky drop flag and saturating drop counter.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      drop_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      drop_err_q <= 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign drop_err_o = drop_err_q;
  assign drop_cnt_o = drop_cnt_q;

`ifdef AXIS_SPLIT_BEAT_CNT_EN
  for (genvar g = 0; g < MASTER_NUM; g++) begin : g_beat
    logic [CNT_WIDTH-1:0] cnt_q;
    // Wrapping count of beats delivered on output g.
    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        cnt_q <= '0;
      end else if (m_tvalid_o[g] & m_tready_i[g]) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign beat_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`else
  assign beat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axis_split_tuser.sv
// Scoreboard bench for axis_split_tuser (MASTER_NUM=3, CNT_WIDTH=4).
// Directed stimulus; monitor checks routing, order and hold.
module tb_axis_split_tuser;
  import axis_split_pkg::*;

  localparam int MN = 3;
  localparam int DW = 32;
  localparam int UW = 2;
  localparam int CW = 4;

  logic           clk_i = 1'b0;
  logic           rstn_i = 1'b0;
  logic           s_tvalid_i = 1'b0;
  logic           s_tready_o;
  logic [DW-1:0]  s_tdata_i = '0;
  logic [UW-1:0]  s_tuser_i = '0;
  logic [MN-1:0]  m_tvalid_o;
  logic [MN-1:0]  m_tready_i = '1;
  logic [DW-1:0]  m_tdata_o;
  logic [UW-1:0]  m_tuser_o;
  logic           drop_err_o;
  logic [CW-1:0]  drop_cnt_o;
  logic [MN*CW-1:0] beat_cnt_o;

  axis_split_tuser #(
    .MASTER_NUM(MN),
    .DATA_WIDTH(DW),
    .USER_WIDTH(UW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .s_tvalid_i(s_tvalid_i),
    .s_tready_o(s_tready_o),
    .s_tdata_i (s_tdata_i),
    .s_tuser_i (s_tuser_i),
    .m_tvalid_o(m_tvalid_o),
    .m_tready_i(m_tready_i),
    .m_tdata_o (m_tdata_o),
    .m_tuser_o (m_tuser_o),
    .drop_err_o(drop_err_o),
    .drop_cnt_o(drop_cnt_o),
    .beat_cnt_o(beat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  beat_t         sb_q[$];
  int            total = 0;
  int            bad = 0;
  int            exp_drop = 0;
  logic [CW-1:0] exp_cnt [MN];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [UW-1:0] u, input logic [DW-1:0] d,
                      output int stalls);
    beat_t b;
    stalls = 0;
    s_tvalid_i = 1'b1;
    s_tuser_i = u;
    s_tdata_i = d;
    @(negedge clk_i);
    while (!s_tready_o && stalls < 200) begin
      stalls++;
      @(negedge clk_i);
    end
    if (!s_tready_o) check("send_timeout", 64'd0, 64'd1);
    if (32'(u) < MN) begin
      b.data = d;
      b.user = u;
      sb_q.push_back(b);
    end else begin
      exp_drop++;
    end
    @(posedge clk_i);
    #1;
    s_tvalid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || m_tvalid_o != '0) && n < 200) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 200) check("drain_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 64'(s_tready_o), 64'd0);
    check("rst_valid", 64'(m_tvalid_o), 64'd0);
    check("rst_data", 64'(m_tdata_o), 64'd0);
    check("rst_user", 64'(m_tuser_o), 64'd0);
    check("rst_drop_err", 64'(drop_err_o), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    check("rst_beat_cnt", 64'(beat_cnt_o), 64'd0);
    sb_q.delete();
    exp_drop = 0;
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("rdy_before_edge", 64'(s_tready_o), 64'd0);
    @(negedge clk_i);
    check("rdy_after_release", 64'(s_tready_o), 64'd1);
    check("valid_after_release", 64'(m_tvalid_o), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_counts();
    logic [CW-1:0] e;
    for (int i = 0; i < MN; i++) begin
`ifdef AXIS_SPLIT_BEAT_CNT_EN
      e = exp_cnt[i];
`else
      e = '0;
`endif
      check($sformatf("beat_cnt[%0d]", i),
            64'(beat_cnt_o[i*CW +: CW]), 64'(e));
    end
    check("drop_cnt", 64'(drop_cnt_o),
          64'((exp_drop > 15) ? 15 : exp_drop));
    check("drop_err", 64'(drop_err_o), 64'(exp_drop != 0));
  endtask

  // Monitor: pop and compare every output handshake.
  initial begin
    logic [MN-1:0] pv;
    logic [DW-1:0] pd;
    logic [MN-1:0] oh;
    logic          hold;
    beat_t         e;
    hold = 1'b0;
    pv = '0;
    pd = '0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        for (int i = 0; i < MN; i++) exp_cnt[i] = '0;
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 64'(m_tvalid_o), 64'(pv));
          check("hold_data", 64'(m_tdata_o), 64'(pd));
        end
        if (m_tvalid_o != '0)
          check("onehot", 64'($onehot(m_tvalid_o)), 64'd1);
        if ((m_tvalid_o & m_tready_i) != '0) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            oh = '0;
            oh[e.user] = 1'b1;
            check("route", 64'(m_tvalid_o), 64'(oh));
            check("data", 64'(m_tdata_o), 64'(e.data));
            check("user", 64'(m_tuser_o), 64'(e.user));
            exp_cnt[e.user] = exp_cnt[e.user] + 1'b1;
          end
        end
        hold = (m_tvalid_o != '0) && ((m_tvalid_o & m_tready_i) == '0);
        pv = m_tvalid_o;
        pd = m_tdata_o;
      end
    end
  end

  initial begin
    int st, sum;
    m_tready_i = '1;
    do_reset();

    sum = 0;
    send(2'd0, 32'hA0, st); sum += st;
    send(2'd1, 32'hA1, st); sum += st;
    send(2'd2, 32'hA2, st); sum += st;
    send(2'd3, 32'hA3, st); sum += st;
    send(2'd0, 32'hB0, st); sum += st;
    check("route_stalls", 64'(sum), 64'd0);
    drain();
    check_counts();

    fork
      begin
        send(2'd2, 32'hC0, st);
        send(2'd2, 32'hC1, st);
        send(2'd2, 32'hC2, st);
      end
      begin
        m_tready_i = 3'b011;
        repeat (4) @(negedge clk_i);
        check("bp_ready", 64'(s_tready_o), 64'd0);
        check("bp_valid", 64'(m_tvalid_o), 64'd4);
        check("bp_data", 64'(m_tdata_o), 64'hC0);
        @(posedge clk_i);
        #1;
        m_tready_i = 3'b111;
      end
    join
    drain();
    check("bp_drained", 64'(sb_q.size()), 64'd0);

    do_reset();
    for (int i = 0; i < 17; i++) send(2'd1, 32'h100 + 32'(i), st);
    drain();
    check_counts();
    for (int i = 0; i < 17; i++) send(2'd3, 32'hD00 + 32'(i), st);
    send(2'd2, 32'hE2, st);
    drain();
    check_counts();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/axis_split_tuser.md
Name: axis_split_tuser

Overview:
- Downstream companion of the round-robin AXIS join arbiter. It consumes the single merged stream, whose tuser carries the index of the granted source, and routes each beat back to one of MASTER_NUM outputs selected by tuser.
- A 2-entry skid buffer on the input keeps s_tready_o registered, so it never depends combinationally on m_tready_i. This isolates the arbiter's combinational grant path.
- Beats with an out-of-range tuser are dropped and counted.

Parameters:
- MASTER_NUM, 4: number of routed outputs; must be ≥2.
- DATA_WIDTH, 32: tdata width.
- USER_WIDTH, $clog2(MASTER_NUM): tuser width; matches the arbiter's index width.
- CNT_WIDTH, 16: width of the drop counter and the optional beat counters.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rstn_i  in  1  synchronous active-low reset.
- s_tvalid_i  in  1  merged stream valid.
- s_tready_o  out  1  merged stream ready; registered.
- s_tdata_i  in  DATA_WIDTH  merged stream data.
- s_tuser_i  in  USER_WIDTH  destination index.
- m_tvalid_o  out  MASTER_NUM  per-output valid; one-hot or zero.
- m_tready_i  in  MASTER_NUM  per-output ready.
- m_tdata_o  out  DATA_WIDTH  head data, broadcast to all outputs.
- m_tuser_o  out  USER_WIDTH  head tuser, broadcast.
- drop_err_o  out  1  sticky flag: an out-of-range beat was dropped.
- drop_cnt_o  out  CNT_WIDTH  count of dropped beats; saturates.
- beat_cnt_o  out  MASTER_NUM*CNT_WIDTH  per-output delivered-beat counters; see Optional Feature.

Behaviour:
- Reset (rstn_i=0 at a clock edge):
  - Buffer state becomes EMPTY; both entries are invalidated.
  - s_tready_o=0, m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, drop_err_o=0, drop_cnt_o=0, beat_cnt_o=0.
  - Reset mid-transfer discards any buffered beats silently.
- Event definitions:
  - accept = s_tvalid_i & s_tready_o.
  - head = main entry; sel = main tuser.
  - oor = sel ≥ MASTER_NUM.
  - pop = main_valid & (oor | m_tready_i[sel]).
- Output rules:
  - m_tvalid_o[i] = main_valid & ~oor & (sel==i).
  - m_tdata_o and m_tuser_o are driven from the main register.
  - Latency from input to output is 1 cycle; sustained throughput is 1 beat/cycle.
- State machine (main/skid entries):
  - EMPTY: accept → load main, go to ONE.
  - ONE:
    - accept & pop → main ← input, stay in ONE.
    - accept & ~pop → skid ← input, go to FULL.
    - ~accept & pop → EMPTY.
    - otherwise hold.
  - FULL:
    - pop → main ← skid, go to ONE.
    - No accept is possible in FULL, because s_tready_o=0.
- s_tready_o: next value = (next_state != FULL). It is therefore 1 in the first cycle after reset release.
- Simultaneous events:
  - Accept and pop in the same cycle in ONE is lossless and keeps beat order.
  - m_tready_i bits for non-selected outputs are ignored.
- Dropping out-of-range beats:
  - An oor head pops in 1 cycle with no m_tvalid_o asserted.
  - drop_cnt_o += 1, saturating at all-ones; drop_err_o is set and held until reset.
  - oor is unreachable when MASTER_NUM is a power of 2; the logic must still synthesise.
- AXIS rules:
  - m_tvalid_o, once high, holds with data stable until the output's ready is seen.
  - The block never deasserts valid without a pop.

Optional Feature:
- Macro: AXIS_SPLIT_BEAT_CNT_EN.
- Defined: beat_cnt_o slice i increments on every m_tvalid_o[i] & m_tready_i[i]. Each slice is CNT_WIDTH wide and wraps modulo 2^CNT_WIDTH.
- Not defined: beat_cnt_o is tied to 0 and no counter flops exist. The port is kept so instantiations do not change.

Decomposition:
- Package axis_split_pkg holds:
  - the enum for buffer state (EMPTY, ONE, FULL);
  - a packed beat typedef {data, user} parameterised via localparams;
  - a function idx_width(n) returning max(1, $clog2(n)).
- Sub-module axis_skid_buf: a generic 2-entry skid buffer with valid/ready/payload. The split logic instantiates it and adds demux, drop and counters on its output side.

Test Plan:
- Reset release: expect s_tready_o=0 during reset, then 1 in the cycle after release, with m_tvalid_o=0.
- Route check: with MASTER_NUM=4 and all m_tready_i=1, send tuser=0,1,2,3 and tdata=0xA0..0xA3 back-to-back. Each output receives exactly one beat one cycle later, with no stalls.
- Backpressure: hold m_tready_i[2]=0 and send 3 beats with tuser=2. After 2 beats s_tready_o goes 0, and m_tvalid_o[2] stays high with tdata stable. Releasing ready drains all 3 beats in order.
- Simultaneous accept/pop: in state ONE, pop and accept in the same cycle. The state stays ONE and no beat is lost or reordered.
- Drop: with MASTER_NUM=3, send tuser=3. No m_tvalid_o is asserted, drop_cnt_o=1 and drop_err_o=1; the next valid beat is routed normally.
- AXIS_SPLIT_BEAT_CNT_EN defined with CNT_WIDTH=4: send 17 beats to output 1. Expect beat_cnt_o slice 1 = 1 (wrapped) and all other slices = 0.
